// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite slave-side signal bundle for ahb_bram_ctrl.
// Handshake: a transfer is accepted on a rising clock edge when
// HSEL & HTRANS[1] & HREADY are all high (address phase). Its data phase is
// the following cycle and ends on the first edge where HREADY is high again.
// The slave stretches a data phase only by driving HREADYOUT low.
interface ahb_bram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave front-end for a dual-port block RAM (write port A, read
// port B). Zero-wait-state reads and writes with byte/half/word strobes and
// read-after-write forwarding for a read issued in a write's data phase.
// Optional feature macro: AHB_BRAM_ERR_EN adds a two-cycle ERROR response for
// misaligned or oversized transfers; without it low address bits are
// truncated and HRESP is tied to OKAY.
// dbg_state exposes the error FSM state (always 0 when the FSM is absent).
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_bram_ctrl_if.slave        ahb,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WEA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_RDATA,
  output logic [1:0]            dbg_state
);

  logic                  acc;
  logic                  err_cond;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] addr_word;
  logic [3:0]            req_mask;

  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_mask;
  logic                  fwd_hit;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;

  // Upper address bits alias by design; HTRANS[0] only separates SEQ/NONSEQ.
  logic unused_bits;
  assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

  function automatic logic [3:0] size_mask(input logic [2:0] size,
                                           input logic [1:0] lo);
    case (size)
      3'd0:    size_mask = 4'b0001 << lo;
      3'd1:    size_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  assign acc       = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign addr_word = ahb.HADDR[ADDR_WIDTH+1:2];
  assign req_mask  = size_mask(ahb.HSIZE, ahb.HADDR[1:0]);
  assign wr_acc    = acc & ahb.HWRITE & ~err_cond;
  assign rd_acc    = acc & ~ahb.HWRITE & ~err_cond;

`ifdef AHB_BRAM_ERR_EN
  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   rdy_out;
  logic   resp_out;

  assign err_cond = (ahb.HSIZE == 3'd1 && ahb.HADDR[0]) ||
                    (ahb.HSIZE == 3'd2 && ahb.HADDR[1:0] != 2'b00) ||
                    (ahb.HSIZE > 3'd2);

  // Error response FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_OK;
    else          state_q <= state_d;
  end

  // Next state and response outputs; ERR2 may accept a new transfer.
  always_comb begin
    state_d  = state_q;
    rdy_out  = 1'b1;
    resp_out = 1'b0;
    case (state_q)
      ST_OK: begin
        if (acc && err_cond) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        rdy_out  = 1'b0;
        resp_out = 1'b1;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        resp_out = 1'b1;
        state_d  = (acc && err_cond) ? ST_ERR1 : ST_OK;
      end
      default: state_d = ST_OK;
    endcase
  end

  assign ahb.HREADYOUT = rdy_out;
  assign ahb.HRESP     = resp_out;
  assign dbg_state     = state_q;
`else
  assign err_cond      = 1'b0;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign dbg_state     = 2'b00;
`endif

  // Capture an accepted write so its data phase can drive the RAM write port.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_mask <= 4'b0000;
    end else begin
      wr_pend <= wr_acc;
      if (wr_acc) begin
        wr_addr <= addr_word;
        wr_mask <= req_mask;
      end
    end
  end

  // A read hitting the word being written this cycle takes the new bytes
  // from HWDATA, since the RAM returns the pre-write contents.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_hit  <= 1'b0;
      fwd_mask <= 4'b0000;
      fwd_data <= 32'h0;
    end else begin
      fwd_hit <= rd_acc & wr_pend & (addr_word == wr_addr);
      if (rd_acc && wr_pend && addr_word == wr_addr) begin
        fwd_mask <= wr_mask;
        fwd_data <= ahb.HWDATA;
      end
    end
  end

  // Read data: per-lane merge of forwarded bytes over RAM output.
  always_comb begin
    ahb.HRDATA = BRAM_RDATA;
    if (fwd_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (fwd_mask[i]) ahb.HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
      end
    end
  end

  // RAM ports: read address follows the bus, write port follows the
  // pending write; ADDRA keeps the last write address while idle.
  assign BRAM_ADDRB = addr_word;
  assign BRAM_ADDRA = wr_addr;
  assign BRAM_WDATA = ahb.HWDATA;
  assign BRAM_WEA   = wr_pend ? wr_mask : 4'b0000;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl with a behavioural dual-port RAM model.
module tb_ahb_bram_ctrl;
  localparam int AW = 14;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic          HCLK;
  logic          HRESETn;
  logic [AW-1:0] bram_addra;
  logic [31:0]   bram_wdata;
  logic [3:0]    bram_wea;
  logic [AW-1:0] bram_addrb;
  logic [31:0]   bram_rdata;
  logic [1:0]    dbg_state;

  logic [31:0] mem [0:(1<<AW)-1];

  int tests_run;
  int tests_failed;

  ahb_bram_ctrl_if ahb_if ();

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .ahb        (ahb_if.slave),
    .BRAM_ADDRA (bram_addra),
    .BRAM_WDATA (bram_wdata),
    .BRAM_WEA   (bram_wea),
    .BRAM_ADDRB (bram_addrb),
    .BRAM_RDATA (bram_rdata),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // RAM model: read-before-write, registered read
  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (bram_wea[i]) mem[bram_addra][8*i +: 8] <= bram_wdata[8*i +: 8];
    bram_rdata <= mem[bram_addrb];
  end

  // driver: one bus cycle, inputs set at negedge, outputs sampled 1ns later
  task automatic drive(input logic sel, input logic [1:0] trans,
                       input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ready);
    @(negedge HCLK);
    ahb_if.HSEL   = sel;
    ahb_if.HTRANS = trans;
    ahb_if.HWRITE = wr;
    ahb_if.HSIZE  = size;
    ahb_if.HADDR  = addr;
    ahb_if.HWDATA = wdata;
    ahb_if.HREADY = ready;
    #1;
  endtask

  task automatic idle(input logic [31:0] wdata);
    drive(1'b0, T_IDLE, 1'b0, 3'd2, 32'h0, wdata, 1'b1);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    idle(32'h0);
    idle(32'h0);
    tests_run++;
    if (bram_wea !== 4'b0000 || ahb_if.HREADYOUT !== 1'b1 ||
        ahb_if.HRESP !== 1'b0 || dbg_state !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset: wea=%b rdy=%b resp=%b st=%0d, want 0000 1 0 0",
               bram_wea, ahb_if.HREADYOUT, ahb_if.HRESP, dbg_state);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    idle(32'h0);
  endtask

  task automatic test_word_write_read();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0, 1'b1);
    idle(32'hDEADBEEF);
    tests_run++;
    if (bram_wea !== 4'hF || bram_addra !== 14'd4 || bram_wdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL word_wr: wea=%h addra=%0d wdata=%h, want f 4 deadbeef",
               bram_wea, bram_addra, bram_wdata);
    end
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'hDEADBEEF || ahb_if.HREADYOUT !== 1'b1 ||
        ahb_if.HRESP !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_rd: hrdata=%h rdy=%b resp=%b, want deadbeef 1 0",
               ahb_if.HRDATA, ahb_if.HREADYOUT, ahb_if.HRESP);
    end
  endtask

  task automatic test_byte_write();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h0, 1'b1);
    drive(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h22, 32'h11223344, 1'b1);
    idle(32'h00AA0000);
    tests_run++;
    if (bram_wea !== 4'b0100) begin
      tests_failed++;
      $display("FAIL byte_wea: wea=%b, want 0100", bram_wea);
    end
    idle(32'h0);
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'h11AA3344) begin
      tests_failed++;
      $display("FAIL byte_rd: hrdata=%h, want 11aa3344", ahb_if.HRDATA);
    end
  endtask

  task automatic test_forward_word();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h30, 32'h0, 1'b1);
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h30, 32'hCAFEF00D, 1'b1);
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL fwd_word: hrdata=%h, want cafef00d", ahb_if.HRDATA);
    end
    // forward clears: RAM now holds the word, read returns it normally
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'h11AA3344) begin
      tests_failed++;
      $display("FAIL fwd_clear: hrdata=%h, want 11aa3344", ahb_if.HRDATA);
    end
  endtask

  task automatic test_forward_half();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h40, 32'h0, 1'b1);
    idle(32'h12345678);
    drive(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h42, 32'h0, 1'b1);
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h40, 32'hBEEF0000, 1'b1);
    tests_run++;
    if (bram_wea !== 4'b1100) begin
      tests_failed++;
      $display("FAIL half_wea: wea=%b, want 1100", bram_wea);
    end
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'hBEEF5678) begin
      tests_failed++;
      $display("FAIL fwd_half: hrdata=%h, want beef5678", ahb_if.HRDATA);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h70, 32'h0, 1'b1);
    drive(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h71, 32'hA1A2A3A4, 1'b1);
    tests_run++;
    if (bram_wea !== 4'hF || bram_addra !== 14'd28) begin
      tests_failed++;
      $display("FAIL b2b_first: wea=%b addra=%0d, want 1111 28", bram_wea, bram_addra);
    end
    idle(32'h0000BB00);
    tests_run++;
    if (bram_wea !== 4'b0010 || bram_addra !== 14'd28) begin
      tests_failed++;
      $display("FAIL b2b_second: wea=%b addra=%0d, want 0010 28", bram_wea, bram_addra);
    end
    idle(32'h0);
    tests_run++;
    if (bram_wea !== 4'b0000 || bram_addra !== 14'd28) begin
      tests_failed++;
      $display("FAIL b2b_idle: wea=%b addra=%0d, want 0000 28", bram_wea, bram_addra);
    end
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h70, 32'h0, 1'b1);
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'hA1A2BBA4) begin
      tests_failed++;
      $display("FAIL b2b_merge: hrdata=%h, want a1a2bba4", ahb_if.HRDATA);
    end
  endtask

  task automatic test_alias();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h0001_0080, 32'h0, 1'b1);
    idle(32'h13579BDF);
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h80, 32'h0, 1'b1);
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'h13579BDF) begin
      tests_failed++;
      $display("FAIL alias: hrdata=%h, want 13579bdf", ahb_if.HRDATA);
    end
  endtask

  task automatic test_no_accept();
    drive(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h90, 32'h0, 1'b1);
    idle(32'h12121212);
    tests_run++;
    if (bram_wea !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hsel0: wea=%b, want 0000", bram_wea);
    end
    drive(1'b1, T_BUSY, 1'b1, 3'd2, 32'h90, 32'h0, 1'b1);
    idle(32'h34343434);
    tests_run++;
    if (bram_wea !== 4'b0000) begin
      tests_failed++;
      $display("FAIL busy: wea=%b, want 0000", bram_wea);
    end
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h90, 32'h0, 1'b0);
    idle(32'h56565656);
    tests_run++;
    if (bram_wea !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hready0: wea=%b, want 0000", bram_wea);
    end
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h50, 32'h0, 1'b1);
    idle(32'h55555555);
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h50, 32'h0, 1'b1);
    idle(32'hFFFFFFFF);
    tests_run++;
    if (bram_wea !== 4'hF) begin
      tests_failed++;
      $display("FAIL rst_pre: wea=%b, want 1111", bram_wea);
    end
    HRESETn = 1'b0;
    #1;
    tests_run++;
    if (bram_wea !== 4'b0000 || ahb_if.HREADYOUT !== 1'b1 || ahb_if.HRESP !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: wea=%b rdy=%b resp=%b, want 0000 1 0",
               bram_wea, ahb_if.HREADYOUT, ahb_if.HRESP);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h50, 32'h0, 1'b1);
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'h55555555) begin
      tests_failed++;
      $display("FAIL rst_keep: hrdata=%h, want 55555555", ahb_if.HRDATA);
    end
  endtask

`ifdef AHB_BRAM_ERR_EN
  task automatic test_error();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h60, 32'h0, 1'b1);
    idle(32'h77777777);
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h61, 32'h0, 1'b1);
    drive(1'b0, T_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF, 1'b0);
    tests_run++;
    if (ahb_if.HREADYOUT !== 1'b0 || ahb_if.HRESP !== 1'b1 || bram_wea !== 4'b0000) begin
      tests_failed++;
      $display("FAIL err1: rdy=%b resp=%b wea=%b, want 0 1 0000",
               ahb_if.HREADYOUT, ahb_if.HRESP, bram_wea);
    end
    idle(32'hFFFFFFFF);
    tests_run++;
    if (ahb_if.HREADYOUT !== 1'b1 || ahb_if.HRESP !== 1'b1 || bram_wea !== 4'b0000) begin
      tests_failed++;
      $display("FAIL err2: rdy=%b resp=%b wea=%b, want 1 1 0000",
               ahb_if.HREADYOUT, ahb_if.HRESP, bram_wea);
    end
    drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h60, 32'h0, 1'b1);
    tests_run++;
    if (ahb_if.HRESP !== 1'b0 || ahb_if.HREADYOUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_done: rdy=%b resp=%b, want 1 0", ahb_if.HREADYOUT, ahb_if.HRESP);
    end
    idle(32'h0);
    tests_run++;
    if (ahb_if.HRDATA !== 32'h77777777) begin
      tests_failed++;
      $display("FAIL err_ram: hrdata=%h, want 77777777", ahb_if.HRDATA);
    end
  endtask
`else
  task automatic test_lenient_size();
    drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h61, 32'h0, 1'b1);
    idle(32'h99887766);
    tests_run++;
    if (bram_wea !== 4'hF || bram_addra !== 14'd24 || ahb_if.HRESP !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign: wea=%b addra=%0d resp=%b, want 1111 24 0",
               bram_wea, bram_addra, ahb_if.HRESP);
    end
    drive(1'b1, T_NONSEQ, 1'b1, 3'd3, 32'h64, 32'h0, 1'b1);
    idle(32'h01020304);
    tests_run++;
    if (bram_wea !== 4'hF || bram_addra !== 14'd25) begin
      tests_failed++;
      $display("FAIL size3: wea=%b addra=%0d, want 1111 25", bram_wea, bram_addra);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    bram_rdata    = 32'h0;
    HRESETn       = 1'b0;
    ahb_if.HSEL   = 1'b0;
    ahb_if.HTRANS = T_IDLE;
    ahb_if.HWRITE = 1'b0;
    ahb_if.HSIZE  = 3'd2;
    ahb_if.HADDR  = 32'h0;
    ahb_if.HWDATA = 32'h0;
    ahb_if.HREADY = 1'b1;

    test_reset();
    test_word_write_read();
    test_byte_write();
    test_forward_word();
    test_forward_half();
    test_back_to_back();
    test_alias();
    test_no_accept();
    test_reset_mid_write();
`ifdef AHB_BRAM_ERR_EN
    test_error();
`else
    test_lenient_size();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
